// File: rtl/execute_stage.sv
// EX pipeline stage: single-cycle ALU and branch resolution plus an iterative
// radix-2 multiplier, with results held in a valid/ready output register.
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      rd,
  input  logic            b_sel,
  input  logic [3:0]      alu_op,
  input  logic [2:0]      br_type,
  input  logic            branch,
  input  logic            jump,
  input  logic            jalr,
  input  logic            memwrite_en,
  input  logic            regwrite_en,
  input  logic            wb_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] writedata,
  output logic [XLEN-1:0] pc_target,
  output logic [4:0]      out_rd,
  output logic            out_memwrite_en,
  output logic            out_regwrite_en,
  output logic            out_wb_sel,
  output logic            pc_sel,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int SHW = (XLEN == 64) ? 6 : 5;
  localparam int CW  = $clog2(XLEN) + 1;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              mhigh_q, mhigh_d;
  logic [XLEN-1:0]   p_wdata_q, p_wdata_d, p_target_q, p_target_d;
  logic [4:0]        p_rd_q, p_rd_d;
  logic              p_mw_q, p_mw_d, p_rw_q, p_rw_d, p_wb_q, p_wb_d, p_psel_q, p_psel_d;

  logic              out_valid_q, out_valid_d, pc_sel_q, pc_sel_d;
  logic [XLEN-1:0]   alu_out_q, alu_out_d, writedata_q, writedata_d, pc_target_q, pc_target_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic              out_mw_q, out_mw_d, out_rw_q, out_rw_d, out_wb_q, out_wb_d;

  logic [XLEN-1:0]   op2_s, alu_res_s, target_s, jsum_s;
  logic [SHW-1:0]    shamt_s;
  logic              cond_s, psel_s, is_mul_s, accept_s;
  logic [XLEN:0]     step_sum_s;
  logic [2*XLEN-1:0] prod_step_s;

  assign busy     = (state_q != S_IDLE);
  assign in_ready = !busy && (!out_valid_q || out_ready);
  assign accept_s = in_valid && in_ready && !flush;
  assign is_mul_s = (alu_op == 4'd10) || (alu_op == 4'd11);
  assign op2_s    = b_sel ? imm : b;
  assign shamt_s  = op2_s[SHW-1:0];

  // Single-cycle ALU result
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    case (alu_op)
      4'd0:    alu_res_s = a + op2_s;
      4'd1:    alu_res_s = a - op2_s;
      4'd2:    alu_res_s = a << shamt_s;
      4'd3:    alu_res_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(op2_s))};
      4'd4:    alu_res_s = {{(XLEN-1){1'b0}}, (a < op2_s)};
      4'd5:    alu_res_s = a ^ op2_s;
      4'd6:    alu_res_s = a >> shamt_s;
      4'd7:    alu_res_s = $unsigned($signed(a) >>> shamt_s);
      4'd8:    alu_res_s = a | op2_s;
      4'd9:    alu_res_s = a & op2_s;
      4'd12:   alu_res_s = op2_s;
      4'd13:   alu_res_s = pc + {{(XLEN-3){1'b0}}, 3'd4};
      default: alu_res_s = {XLEN{1'b0}};
    endcase
  end

  // Branch condition and control-flow target
  always_comb begin
    cond_s = 1'b0;
    case (br_type)
      3'b000:  cond_s = (a == b);
      3'b001:  cond_s = (a != b);
      3'b100:  cond_s = ($signed(a) < $signed(b));
      3'b101:  cond_s = ($signed(a) >= $signed(b));
      3'b110:  cond_s = (a < b);
      3'b111:  cond_s = (a >= b);
      default: cond_s = 1'b0;
    endcase
    psel_s = jump || (branch && cond_s);
    jsum_s = a + imm;
    if (jalr) begin
      target_s = {jsum_s[XLEN-1:1], 1'b0};
    end else begin
      target_s = pc + imm;
    end
  end

  // One shift-add step: add multiplicand into the upper half when the low bit is set
  assign step_sum_s  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                       (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
  assign prod_step_s = {step_sum_s, prod_q[XLEN-1:1]};

  // Next-state for the multiplier FSM and the output register
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; mcand_d = mcand_q; prod_d = prod_q; mhigh_d = mhigh_q;
    p_wdata_d = p_wdata_q; p_target_d = p_target_q; p_rd_d = p_rd_q;
    p_mw_d = p_mw_q; p_rw_d = p_rw_q; p_wb_d = p_wb_q; p_psel_d = p_psel_q;
    out_valid_d = out_valid_q; alu_out_d = alu_out_q; writedata_d = writedata_q;
    pc_target_d = pc_target_q; out_rd_d = out_rd_q; out_mw_d = out_mw_q;
    out_rw_d = out_rw_q; out_wb_d = out_wb_q; pc_sel_d = pc_sel_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s && is_mul_s) begin
          state_d    = S_MUL;
          cnt_d      = {CW{1'b0}};
          mcand_d    = a;
          prod_d     = {{XLEN{1'b0}}, op2_s};
          mhigh_d    = (alu_op == 4'd11);
          p_wdata_d  = b;
          p_target_d = target_s;
          p_rd_d     = rd;
          p_mw_d     = memwrite_en;
          p_rw_d     = regwrite_en;
          p_wb_d     = wb_sel;
          p_psel_d   = psel_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        prod_d = prod_step_s;
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flush outranks everything; a new result outranks retiring the held one
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      pc_sel_d    = 1'b0;
      out_mw_d    = 1'b0;
      out_rw_d    = 1'b0;
    end else if (accept_s && !is_mul_s) begin
      out_valid_d = 1'b1;
      alu_out_d   = alu_res_s;
      writedata_d = b;
      pc_target_d = target_s;
      out_rd_d    = rd;
      out_mw_d    = memwrite_en;
      out_rw_d    = regwrite_en;
      out_wb_d    = wb_sel;
      pc_sel_d    = psel_s;
    end else if (state_q == S_DONE) begin
      out_valid_d = 1'b1;
      alu_out_d   = mhigh_q ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
      writedata_d = p_wdata_q;
      pc_target_d = p_target_q;
      out_rd_d    = p_rd_q;
      out_mw_d    = p_mw_q;
      out_rw_d    = p_rw_q;
      out_wb_d    = p_wb_q;
      pc_sel_d    = p_psel_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; cnt_q <= {CW{1'b0}}; mcand_q <= {XLEN{1'b0}};
      prod_q <= {(2*XLEN){1'b0}}; mhigh_q <= 1'b0;
      p_wdata_q <= {XLEN{1'b0}}; p_target_q <= {XLEN{1'b0}}; p_rd_q <= 5'd0;
      p_mw_q <= 1'b0; p_rw_q <= 1'b0; p_wb_q <= 1'b0; p_psel_q <= 1'b0;
      out_valid_q <= 1'b0; alu_out_q <= {XLEN{1'b0}}; writedata_q <= {XLEN{1'b0}};
      pc_target_q <= {XLEN{1'b0}}; out_rd_q <= 5'd0; out_mw_q <= 1'b0;
      out_rw_q <= 1'b0; out_wb_q <= 1'b0; pc_sel_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; mcand_q <= mcand_d;
      prod_q <= prod_d; mhigh_q <= mhigh_d;
      p_wdata_q <= p_wdata_d; p_target_q <= p_target_d; p_rd_q <= p_rd_d;
      p_mw_q <= p_mw_d; p_rw_q <= p_rw_d; p_wb_q <= p_wb_d; p_psel_q <= p_psel_d;
      out_valid_q <= out_valid_d; alu_out_q <= alu_out_d; writedata_q <= writedata_d;
      pc_target_q <= pc_target_d; out_rd_q <= out_rd_d; out_mw_q <= out_mw_d;
      out_rw_q <= out_rw_d; out_wb_q <= out_wb_d; pc_sel_q <= pc_sel_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign alu_out         = alu_out_q;
  assign writedata       = writedata_q;
  assign pc_target       = pc_target_q;
  assign out_rd          = out_rd_q;
  assign out_memwrite_en = out_mw_q;
  assign out_regwrite_en = out_rw_q;
  assign out_wb_sel      = out_wb_q;
  assign pc_sel          = pc_sel_q;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [31:0] a, b, imm, pc, alu_out, writedata, pc_target;
  logic [4:0] rd, out_rd;
  logic b_sel, branch, jump, jalr, memwrite_en, regwrite_en, wb_sel;
  logic out_memwrite_en, out_regwrite_en, out_wb_sel, pc_sel;
  logic [3:0] alu_op;
  logic [2:0] br_type;

  execute_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .a(a), .b(b), .imm(imm), .pc(pc), .rd(rd), .b_sel(b_sel), .alu_op(alu_op),
    .br_type(br_type), .branch(branch), .jump(jump), .jalr(jalr),
    .memwrite_en(memwrite_en), .regwrite_en(regwrite_en), .wb_sel(wb_sel),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .writedata(writedata), .pc_target(pc_target), .out_rd(out_rd),
    .out_memwrite_en(out_memwrite_en), .out_regwrite_en(out_regwrite_en),
    .out_wb_sel(out_wb_sel), .pc_sel(pc_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] a, b, imm, pc;
    logic [4:0]  rd;
    logic        b_sel;
    logic [3:0]  alu_op;
    logic [2:0]  br_type;
    logic        branch, jump, jalr, mw, rw, wb;
  } instr_t;

  typedef struct packed {
    logic [31:0] alu, wd, tgt;
    logic [4:0]  rd;
    logic        mw, rw, wb, psel;
  } res_t;

  function automatic res_t model(input instr_t i);
    res_t r;
    logic [31:0] y;
    logic [63:0] p;
    int sh, s;
    logic take;
    y = i.b_sel ? i.imm : i.b;
    sh = int'(y & 32'd31);
    s = int'(i.a);
    p = {32'd0, i.a} * {32'd0, y};
    case (i.alu_op)
      4'd0:  r.alu = i.a + y;
      4'd1:  r.alu = i.a - y;
      4'd2:  r.alu = i.a << sh;
      4'd3:  r.alu = (int'(i.a) < int'(y)) ? 32'd1 : 32'd0;
      4'd4:  r.alu = (i.a < y) ? 32'd1 : 32'd0;
      4'd5:  r.alu = i.a ^ y;
      4'd6:  r.alu = i.a >> sh;
      4'd7:  r.alu = 32'(s >>> sh);
      4'd8:  r.alu = i.a | y;
      4'd9:  r.alu = i.a & y;
      4'd10: r.alu = p[31:0];
      4'd11: r.alu = p[63:32];
      4'd12: r.alu = y;
      4'd13: r.alu = i.pc + 32'd4;
      default: r.alu = 32'd0;
    endcase
    case (i.br_type)
      3'd0: take = (i.a == i.b);
      3'd1: take = (i.a != i.b);
      3'd4: take = (int'(i.a) < int'(i.b));
      3'd5: take = (int'(i.a) >= int'(i.b));
      3'd6: take = (i.a < i.b);
      3'd7: take = (i.a >= i.b);
      default: take = 1'b0;
    endcase
    r.psel = i.jump | (i.branch & take);
    r.tgt  = i.jalr ? ((i.a + i.imm) & 32'hFFFF_FFFE) : (i.pc + i.imm);
    r.wd = i.b; r.rd = i.rd; r.mw = i.mw; r.rw = i.rw; r.wb = i.wb;
    return r;
  endfunction

  function automatic instr_t mk(input logic [3:0] op, input logic [31:0] ia, ib, iimm, ipc,
                                input logic bs);
    instr_t i;
    i = '0;
    i.alu_op = op; i.a = ia; i.b = ib; i.imm = iimm; i.pc = ipc; i.b_sel = bs;
    return i;
  endfunction

  function automatic instr_t gen(input int mul_pct);
    instr_t i;
    i = '0;
    i.a = $urandom; i.b = $urandom; i.imm = $urandom; i.pc = $urandom;
    if ($urandom_range(0, 3) == 0) i.b = i.a;
    i.rd = 5'($urandom_range(0, 31));
    i.b_sel = 1'($urandom_range(0, 1));
    i.alu_op = 4'($urandom_range(0, 15));
    if (i.alu_op == 4'd10 || i.alu_op == 4'd11) i.alu_op = 4'd0;
    if ($urandom_range(0, 99) < mul_pct) i.alu_op = 4'($urandom_range(10, 11));
    i.br_type = 3'($urandom_range(0, 7));
    i.branch = 1'($urandom_range(0, 1)); i.jump = ($urandom_range(0, 3) == 0);
    i.jalr = 1'($urandom_range(0, 1)); i.mw = 1'($urandom_range(0, 1));
    i.rw = 1'($urandom_range(0, 1)); i.wb = 1'($urandom_range(0, 1));
    return i;
  endfunction

  function automatic res_t obs();
    return {alu_out, writedata, pc_target, out_rd, out_memwrite_en, out_regwrite_en,
            out_wb_sel, pc_sel};
  endfunction

  task automatic drive(input instr_t i, input logic v);
    a = i.a; b = i.b; imm = i.imm; pc = i.pc; rd = i.rd; b_sel = i.b_sel;
    alu_op = i.alu_op; br_type = i.br_type; branch = i.branch; jump = i.jump;
    jalr = i.jalr; memwrite_en = i.mw; regwrite_en = i.rw; wb_sel = i.wb; in_valid = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive('0, 1'b0);
  endtask

  // Presents i for one cycle with out_ready=1 and checks the result appears next cycle
  task automatic issue_check(input instr_t i, input string name);
    res_t e;
    e = model(i);
    out_ready = 1'b1; drive(i, 1'b1); #1;
    tick(); idle(); #1;
    tests_run++;
    if (out_valid !== 1'b1 || obs() !== e) begin
      tests_failed++;
      $display("FAIL %s: got valid=%b res=%h, want valid=1 res=%h", name, out_valid, obs(), e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; idle();
    tick(); tick();
    rst = 1'b0; #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || obs() !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b busy=%b res=%h, want 0 0 0", out_valid, busy, obs());
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    instr_t i;
    i = mk(4'd0, 32'd5, 32'd0, 32'd7, 32'd0, 1'b1);
    issue_check(i, "add_imm");
    tests_run++;
    if (alu_out !== 32'd12 || pc_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_value: got alu=%h pc_sel=%b, want 0000000c 0", alu_out, pc_sel);
    end
    i = mk(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 1'b0);
    i.branch = 1'b1; i.br_type = 3'b100;
    issue_check(i, "blt");
    tests_run++;
    if (pc_sel !== 1'b1 || pc_target !== 32'h120) begin
      tests_failed++;
      $display("FAIL blt_taken: got pc_sel=%b tgt=%h, want 1 00000120", pc_sel, pc_target);
    end
    i.br_type = 3'b110;
    issue_check(i, "bltu");
    tests_run++;
    if (pc_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL bltu_not_taken: got pc_sel=%b, want 0", pc_sel);
    end
    i = mk(4'd0, 32'h1001, 32'd0, 32'd4, 32'd0, 1'b1);
    i.jalr = 1'b1; i.jump = 1'b1;
    issue_check(i, "jalr");
    tests_run++;
    if (pc_sel !== 1'b1 || pc_target !== 32'h1004) begin
      tests_failed++;
      $display("FAIL jalr_target: got pc_sel=%b tgt=%h, want 1 00001004", pc_sel, pc_target);
    end
    i = mk(4'd13, 32'd0, 32'd0, 32'd0, 32'h200, 1'b0);
    issue_check(i, "link");
    tests_run++;
    if (alu_out !== 32'h204) begin
      tests_failed++;
      $display("FAIL link_value: got %h, want 00000204", alu_out);
    end
    i = mk(4'd2, 32'h1, 32'h25, 32'd0, 32'd0, 1'b0);
    issue_check(i, "sll_shamt_mask");
    i = mk(4'd7, 32'h8000_0000, 32'd31, 32'd0, 32'd0, 1'b0);
    issue_check(i, "sra_31");
    i = mk(4'd15, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
    issue_check(i, "op15_zero");
  endtask

  task automatic test_mul(input logic [3:0] op, input logic [31:0] want);
    instr_t i;
    res_t e;
    int bad;
    i = mk(op, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h40, 1'b0);
    i.rd = 5'd9; i.rw = 1'b1;
    e = model(i);
    out_ready = 1'b1; drive(i, 1'b1); #1;
    tick(); idle(); #1;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      tick(); #1;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL mul_busy_window: got %0d bad cycles, want 0", bad);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_early_valid: got valid=%b at cycle 32, want 0", out_valid);
    end
    tick(); #1;
    tests_run++;
    if (out_valid !== 1'b1 || obs() !== e || alu_out !== want) begin
      tests_failed++;
      $display("FAIL mul_result op%0d: got valid=%b alu=%h res=%h, want 1 %h %h",
               op, out_valid, alu_out, obs(), want, e);
    end
    tick(); #1;
  endtask

  task automatic test_backpressure();
    instr_t ia, ib;
    res_t ea, eb;
    int bad;
    ia = gen(0); ib = gen(0);
    ea = model(ia); eb = model(ib);
    out_ready = 1'b0; drive(ia, 1'b1); #1;
    tick(); drive(ib, 1'b1); #1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs() !== ea) bad++;
      tick(); #1;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d bad cycles, want 0", bad);
    end
    out_ready = 1'b1; #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_release_ready: got %b, want 1", in_ready);
    end
    tick(); idle(); #1;
    tests_run++;
    if (out_valid !== 1'b1 || obs() !== eb) begin
      tests_failed++;
      $display("FAIL stall_next: got valid=%b res=%h, want 1 %h", out_valid, obs(), eb);
    end
    tick(); #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_drain: got valid=%b, want 0", out_valid);
    end
  endtask

  // Starts a multiply, kills it at MUL cycle 10 with flush or rst, and watches for a stray result
  task automatic test_kill_mul(input logic use_rst);
    instr_t i;
    int seen;
    issue_check(mk(4'd8, 32'hA5A5_0000, 32'h0000_5A5A, 32'd0, 32'h300, 1'b0), "pre_kill_op");
    i = mk(4'd10, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0);
    i.rw = 1'b1;
    out_ready = 1'b1; drive(i, 1'b1); #1;
    tick(); idle();
    for (int k = 0; k < 10; k++) tick();
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    drive(gen(0), 1'b1);
    tick(); rst = 1'b0; flush = 1'b0; idle(); #1;
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL kill_mul rst=%b: got busy=%b valid=%b, want 0 0", use_rst, busy, out_valid);
    end
    if (use_rst) begin
      tests_run++;
      if (obs() !== '0 || in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL rst_outputs: got res=%h in_ready=%b, want 0 1", obs(), in_ready);
      end
    end
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      tick(); #1;
      if (out_valid === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL kill_no_result rst=%b: got %0d valid cycles, want 0", use_rst, seen);
    end
  endtask

  task automatic test_flush();
    instr_t i;
    i = gen(0); i.jump = 1'b1; i.rw = 1'b1; i.mw = 1'b1;
    out_ready = 1'b0; drive(i, 1'b1); #1;
    tick(); idle(); flush = 1'b1; #1;
    tick(); flush = 1'b0; #1;
    tests_run++;
    if (out_valid !== 1'b0 || pc_sel !== 1'b0 || out_regwrite_en !== 1'b0 || out_memwrite_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_clears: got valid=%b psel=%b rw=%b mw=%b, want 0 0 0 0",
               out_valid, pc_sel, out_regwrite_en, out_memwrite_en);
    end
    out_ready = 1'b1; flush = 1'b1; drive(gen(0), 1'b1); #1;
    tick(); flush = 1'b0; idle(); #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_priority: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_random_single();
    for (int n = 0; n < 60; n++) issue_check(gen(0), "random_alu");
    tick();
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t e;
    instr_t i;
    logic v;
    for (int cyc = 0; cyc < 700; cyc++) begin
      i = gen(8); v = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      if (cyc >= 600) begin v = 1'b0; out_ready = 1'b1; end
      drive(i, v); #1;
      if (out_valid === 1'b1 && out_ready) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL stream_dup: got res=%h with nothing pending", obs());
        end else begin
          e = q.pop_front();
          if (obs() !== e) begin
            tests_failed++;
            $display("FAIL stream_data: got %h, want %h", obs(), e);
          end
        end
      end
      if (in_ready === 1'b1 && out_valid === 1'b1 && !out_ready) begin
        tests_run++; tests_failed++;
        $display("FAIL stream_ready: in_ready=1 while result stalled");
      end
      if (v && in_ready === 1'b1) q.push_back(model(i));
      tick();
    end
    tests_run++;
    if (q.size() != 0) begin
      tests_failed++;
      $display("FAIL stream_lost: got %0d results never delivered, want 0", q.size());
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; idle();
    #2;
    test_reset();
    test_directed();
    test_mul(4'd11, 32'hFFFF_FFFE);
    test_mul(4'd10, 32'h0000_0001);
    test_backpressure();
    test_flush();
    test_kill_mul(1'b0);
    test_kill_mul(1'b1);
    test_random_single();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
